// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit
//
// Purpose:
//   Execute-stage control-flow resolver with a fetch-side, direct-mapped
//   branch target buffer (BTB) for the pipelined RV32I core.
//     - Fetch side: combinational BTB lookup on PCF gives a next-PC prediction.
//     - Execute side: evaluates the branch condition, computes the correct next
//       PC, flags a mispredict and asks the F/D and D/E registers to flush.
//     - Training: 2-bit saturating counters and targets are updated as
//       conditional branches and JALs resolve (JALR never trains).
//
// Optional feature macro:
//   BRANCH_STATS_EN - when defined, BranchCount / MispredictCount are live
//                     wrapping counters; when undefined they are tied to 0.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   PCF                         fetch PC
//   PredTakenF, PredTargetF     BTB prediction for PCF
//   ValidE, StallE              E-stage holds a real instruction / is held
//   BranchE, JumpE, JALRE       decoded control (JALR asserts JumpE too)
//   funct3E, SrcAE, SrcBE       branch condition and operands
//   PCE, PCPlus4E, PCTargetE,
//   ALUResultE                  E-stage PC candidates
//   PredTakenE, PredTargetE     fetch prediction carried down the pipe
//   RedirectE, RedirectPCE      mispredict and the correct next PC
//   FlushD, FlushE              flush requests (equal to RedirectE)
//   BranchCount, MispredictCount statistics
// ============================================================================
module branch_resolve_unit #(
   parameter int WIDTH       = 32,
   parameter int BTB_ENTRIES = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     PCF,
   output logic                 PredTakenF,
   output logic [WIDTH-1:0]     PredTargetF,
   input  logic                 ValidE,
   input  logic                 StallE,
   input  logic                 BranchE,
   input  logic                 JumpE,
   input  logic                 JALRE,
   input  logic [2:0]           funct3E,
   input  logic [WIDTH-1:0]     SrcAE,
   input  logic [WIDTH-1:0]     SrcBE,
   input  logic [WIDTH-1:0]     PCE,
   input  logic [WIDTH-1:0]     PCPlus4E,
   input  logic [WIDTH-1:0]     PCTargetE,
   input  logic [WIDTH-1:0]     ALUResultE,
   input  logic                 PredTakenE,
   input  logic [WIDTH-1:0]     PredTargetE,
   output logic                 RedirectE,
   output logic [WIDTH-1:0]     RedirectPCE,
   output logic                 FlushD,
   output logic                 FlushE,
   output logic [CNT_WIDTH-1:0] BranchCount,
   output logic [CNT_WIDTH-1:0] MispredictCount
);

   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = WIDTH - IDX - 2;

   logic             btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
   logic [1:0]       btb_cnt    [BTB_ENTRIES];
   logic [WIDTH-1:0] btb_target [BTB_ENTRIES];

   logic [IDX-1:0]   f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   logic [IDX-1:0]   e_idx;
   logic [TAG_W-1:0] e_tag;
   logic             e_hit;
   logic             cond;
   logic             taken;
   logic [WIDTH-1:0] next_pc;
   logic             mispredict;
   logic             upd;

   // Instruction-alignment bits and the JALR LSB are architecturally ignored.
   logic unused_bits;
   assign unused_bits = ^{PCF[1:0], PCE[1:0], ALUResultE[0]};

   assign f_idx = PCF[IDX+1:2];
   assign f_tag = PCF[WIDTH-1:IDX+2];
   assign e_idx = PCE[IDX+1:2];
   assign e_tag = PCE[WIDTH-1:IDX+2];

   // Fetch-side lookup. The counter's MSB set means "weakly or strongly taken".
   always_comb begin
      f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
      PredTakenF  = f_hit && btb_cnt[f_idx][1];
      PredTargetF = f_hit ? btb_target[f_idx] : '0;
   end

   // Execute-side resolution: branch condition, true next PC and mispredict.
   // A correct direction is still a mispredict when a taken prediction
   // pointed at the wrong target.
   always_comb begin
      cond = 1'b0;
      unique case (funct3E)
         3'b000:  cond = (SrcAE == SrcBE);
         3'b001:  cond = (SrcAE != SrcBE);
         3'b100:  cond = ($signed(SrcAE) <  $signed(SrcBE));
         3'b101:  cond = ($signed(SrcAE) >= $signed(SrcBE));
         3'b110:  cond = (SrcAE <  SrcBE);
         3'b111:  cond = (SrcAE >= SrcBE);
         default: cond = 1'b0;
      endcase
      taken = (BranchE && cond) || JumpE;
      if (JumpE && JALRE)
         next_pc = {ALUResultE[WIDTH-1:1], 1'b0};
      else if (taken)
         next_pc = PCTargetE;
      else
         next_pc = PCPlus4E;
      mispredict  = (PredTakenE != taken) ||
                    (PredTakenE && taken && (PredTargetE != next_pc));
      RedirectE   = ValidE && mispredict;
      RedirectPCE = RedirectE ? next_pc : '0;
      FlushD      = RedirectE;
      FlushE      = RedirectE;
   end

   // Training qualifier: a stalled E stage must not train twice, and JALR
   // targets are register-dependent so they are never cached.
   always_comb begin
      upd   = ValidE && !StallE && (BranchE || (JumpE && !JALRE));
      e_hit = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
   end

   // BTB storage. Conditional branches move their counter by one step and
   // only allocate when taken; JALs always (re)install as strongly taken,
   // overwriting whatever aliased into the same index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_cnt[i]    <= 2'd0;
            btb_target[i] <= '0;
         end
      end else if (upd) begin
         if (BranchE) begin
            if (e_hit) begin
               if (taken) begin
                  if (btb_cnt[e_idx] != 2'd3)
                     btb_cnt[e_idx] <= btb_cnt[e_idx] + 2'd1;
                  btb_target[e_idx] <= PCTargetE;
               end else if (btb_cnt[e_idx] != 2'd0) begin
                  btb_cnt[e_idx] <= btb_cnt[e_idx] - 2'd1;
               end
            end else if (taken) begin
               btb_valid[e_idx]  <= 1'b1;
               btb_tag[e_idx]    <= e_tag;
               btb_target[e_idx] <= PCTargetE;
               btb_cnt[e_idx]    <= 2'd2;
            end
         end else begin
            btb_valid[e_idx]  <= 1'b1;
            btb_tag[e_idx]    <= e_tag;
            btb_target[e_idx] <= PCTargetE;
            btb_cnt[e_idx]    <= 2'd3;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   // Statistics count once per retired E-stage event; both wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         BranchCount     <= '0;
         MispredictCount <= '0;
      end else if (ValidE && !StallE) begin
         if (BranchE)
            BranchCount <= BranchCount + 1'b1;
         if (RedirectE)
            MispredictCount <= MispredictCount + 1'b1;
      end
   end
`else
   assign BranchCount     = '0;
   assign MispredictCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// tb_branch_resolve_unit
//
// Purpose:
//   Self-checking bench for branch_resolve_unit: a table of resolution
//   vectors, hand-written multi-cycle sequences (reset, cold allocation,
//   counter saturation, JALR, stall hold) and a randomized phase compared
//   against a behavioural BTB model kept here.
//   Expected statistics follow BRANCH_STATS_EN when it is defined.
// ============================================================================
`timescale 1ns/1ps
module tb_branch_resolve_unit;

   localparam int WIDTH   = 32;
   localparam int ENTRIES = 16;
   localparam int IDX     = 4;

   typedef struct packed {
      logic        valid;
      logic        stall;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pce;
      logic [31:0] pc_target;
      logic [31:0] alu;
      logic        pred_taken;
      logic [31:0] pred_target;
   } e_op_t;

   typedef struct packed {
      e_op_t       op;
      logic        exp_redirect;
      logic [31:0] exp_pc;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] PCF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        ValidE, StallE, BranchE, JumpE, JALRE;
   logic [2:0]  funct3E;
   logic [31:0] SrcAE, SrcBE, PCE, PCPlus4E, PCTargetE, ALUResultE;
   logic        PredTakenE;
   logic [31:0] PredTargetE;
   logic        RedirectE;
   logic [31:0] RedirectPCE;
   logic        FlushD, FlushE;
   logic [31:0] BranchCount, MispredictCount;

   branch_resolve_unit #(.WIDTH(WIDTH), .BTB_ENTRIES(ENTRIES), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .PCF(PCF),
      .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
      .ValidE(ValidE), .StallE(StallE), .BranchE(BranchE), .JumpE(JumpE), .JALRE(JALRE),
      .funct3E(funct3E), .SrcAE(SrcAE), .SrcBE(SrcBE),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
      .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
      .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
      .FlushD(FlushD), .FlushE(FlushE),
      .BranchCount(BranchCount), .MispredictCount(MispredictCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   e_op_t cur_op;
   vec_t  vecs[17];

   // Behavioural BTB: entry slot = word address modulo entry count,
   // tag = everything above the index bits.
   bit          m_valid  [ENTRIES];
   logic [31:0] m_tag    [ENTRIES];
   int          m_cnt    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   logic [31:0] m_branch_count;
   logic [31:0] m_mis_count;

   function automatic int slot(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc >> (IDX + 2);
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
   endfunction

   function automatic bit model_pred_taken(input logic [31:0] pc);
      return model_hit(pc) && (m_cnt[slot(pc)] >= 2);
   endfunction

   function automatic logic [31:0] model_pred_target(input logic [31:0] pc);
      return model_hit(pc) ? m_target[slot(pc)] : 32'h0;
   endfunction

   function automatic bit model_taken(input e_op_t op);
      bit c;
      case (op.f3)
         3'd0:    c = (op.a == op.b);
         3'd1:    c = (op.a != op.b);
         3'd4:    c = (int'(op.a) <  int'(op.b));
         3'd5:    c = (int'(op.a) >= int'(op.b));
         3'd6:    c = (op.a <  op.b);
         3'd7:    c = (op.a >= op.b);
         default: c = 1'b0;
      endcase
      return (op.branch && c) || op.jump;
   endfunction

   function automatic logic [31:0] model_next_pc(input e_op_t op);
      if (op.jump && op.jalr) return op.alu & 32'hFFFF_FFFE;
      if (model_taken(op))    return op.pc_target;
      return op.pce + 32'd4;
   endfunction

   function automatic bit model_redirect(input e_op_t op);
      bit tk;
      tk = model_taken(op);
      return op.valid && ((op.pred_taken != tk) ||
                          (tk && (op.pred_target != model_next_pc(op))));
   endfunction

   function automatic logic [31:0] exp_branch_count();
`ifdef BRANCH_STATS_EN
      return m_branch_count;
`else
      return 32'h0;
`endif
   endfunction

   function automatic logic [31:0] exp_mis_count();
`ifdef BRANCH_STATS_EN
      return m_mis_count;
`else
      return 32'h0;
`endif
   endfunction

   task automatic model_clear();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 32'h0; m_cnt[i] = 0; m_target[i] = 32'h0;
      end
      m_branch_count = 32'h0;
      m_mis_count    = 32'h0;
   endtask

   task automatic model_train(input logic [31:0] pc, input bit is_branch,
                              input bit tk, input logic [31:0] tgt);
      int s;
      s = slot(pc);
      if (!is_branch) begin
         m_valid[s] = 1'b1; m_tag[s] = tag_of(pc); m_target[s] = tgt; m_cnt[s] = 3;
      end else if (model_hit(pc)) begin
         m_cnt[s] = m_cnt[s] + (tk ? 1 : -1);
         if (m_cnt[s] > 3) m_cnt[s] = 3;
         if (m_cnt[s] < 0) m_cnt[s] = 0;
         if (tk) m_target[s] = tgt;
      end else if (tk) begin
         m_valid[s] = 1'b1; m_tag[s] = tag_of(pc); m_target[s] = tgt; m_cnt[s] = 2;
      end
   endtask

   function automatic e_op_t make_op(input logic valid, stall, branch, jump, jalr,
                                     input logic [2:0] f3,
                                     input logic [31:0] a, b, pce, pc_target, alu,
                                     input logic pred_taken,
                                     input logic [31:0] pred_target);
      e_op_t op;
      op.valid = valid; op.stall = stall; op.branch = branch; op.jump = jump; op.jalr = jalr;
      op.f3 = f3; op.a = a; op.b = b; op.pce = pce; op.pc_target = pc_target; op.alu = alu;
      op.pred_taken = pred_taken; op.pred_target = pred_target;
      return op;
   endfunction

   function automatic vec_t make_vec(input logic valid, branch, jump, jalr,
                                     input logic [2:0] f3,
                                     input logic [31:0] a, b, pce, pc_target, alu,
                                     input logic pred_taken,
                                     input logic [31:0] pred_target,
                                     input logic exp_redirect,
                                     input logic [31:0] exp_pc);
      vec_t v;
      v.op = make_op(valid, 1'b1, branch, jump, jalr, f3, a, b, pce, pc_target, alu,
                     pred_taken, pred_target);
      v.exp_redirect = exp_redirect;
      v.exp_pc       = exp_pc;
      return v;
   endfunction

   task automatic applyStimulus(input e_op_t op);
      cur_op      = op;
      ValidE      = op.valid;
      StallE      = op.stall;
      BranchE     = op.branch;
      JumpE       = op.jump;
      JALRE       = op.jalr;
      funct3E     = op.f3;
      SrcAE       = op.a;
      SrcBE       = op.b;
      PCE         = op.pce;
      PCPlus4E    = op.pce + 32'd4;
      PCTargetE   = op.pc_target;
      ALUResultE  = op.alu;
      PredTakenE  = op.pred_taken;
      PredTargetE = op.pred_target;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Advance one clock edge and mirror in the model whatever the edge commits.
   task automatic step();
      e_op_t op;
      bit    red, tk, upd;
      op  = cur_op;
      red = model_redirect(op);
      tk  = model_taken(op);
      upd = op.valid && !op.stall && (op.branch || (op.jump && !op.jalr));
      @(posedge clk);
      if (rst_n) begin
         if (upd) model_train(op.pce, op.branch, tk, op.pc_target);
         if (op.valid && !op.stall) begin
            if (op.branch) m_branch_count = m_branch_count + 32'd1;
            if (red)       m_mis_count    = m_mis_count + 32'd1;
         end
      end
      #1;
   endtask

   task automatic check_fetch(input string name, input logic [31:0] pc,
                              input logic exp_taken, input logic [31:0] exp_target);
      PCF = pc;
      #1;
      checkOutput({name, " PredTakenF"}, PredTakenF, exp_taken);
      checkOutput({name, " PredTargetF"}, PredTargetF, exp_target);
   endtask

   task automatic check_redirect(input string name, input logic exp_red,
                                 input logic [31:0] exp_pc);
      checkOutput({name, " RedirectE"}, RedirectE, exp_red);
      checkOutput({name, " RedirectPCE"}, RedirectPCE, exp_pc);
      checkOutput({name, " FlushD"}, FlushD, exp_red);
      checkOutput({name, " FlushE"}, FlushE, exp_red);
   endtask

   function automatic logic [31:0] rand_pc();
      return ({30'h0, 2'($urandom_range(0, 3))} << 6) | ({28'h0, 4'($urandom_range(0, 3))} << 2);
   endfunction

   initial begin
      e_op_t idle, beq_cold, bne_t, bne_nt, jalr_op, op;
      bit    exp_red;
      logic [31:0] exp_nx;
      string nm;

      idle     = make_op(0,0,0,0,0,3'd0,0,0,0,0,0,0,0);
      beq_cold = make_op(1,0,1,0,0,3'd0,32'd5,32'd5,32'h100,32'h140,0,0,0);
      bne_t    = make_op(1,0,1,0,0,3'd1,32'd5,32'd6,32'h200,32'h240,0,0,0);
      bne_nt   = make_op(1,0,1,0,0,3'd1,32'd7,32'd7,32'h200,32'h240,0,0,0);
      jalr_op  = make_op(1,0,0,1,1,3'd0,0,0,32'h300,32'h340,32'h1235,0,0);

      // ---------------- power-on reset ----------------
      rst_n = 1'b0;
      PCF   = 32'h100;
      applyStimulus(idle);
      model_clear();
      #12;
      checkOutput("reset PredTakenF", PredTakenF, 1'b0);
      checkOutput("reset PredTargetF", PredTargetF, 32'h0);
      checkOutput("reset BranchCount", BranchCount, 32'h0);
      checkOutput("reset MispredictCount", MispredictCount, 32'h0);
      rst_n = 1'b1;
      step();
      check_fetch("post-reset lookup 0x100", 32'h100, 1'b0, 32'h0);

      // ---------------- cold BEQ ----------------
      applyStimulus(beq_cold);
      check_fetch("cold BEQ same-cycle lookup", 32'h100, 1'b0, 32'h0);
      check_redirect("cold BEQ", 1'b1, 32'h140);
      step();
      applyStimulus(idle);
      check_fetch("cold BEQ trained", 32'h100, 1'b1, 32'h140);

      // ---------------- asynchronous reset mid-update ----------------
      applyStimulus(beq_cold);
      #1;
      rst_n = 1'b0;
      #1;
      model_clear();
      checkOutput("mid reset PredTakenF", PredTakenF, 1'b0);
      checkOutput("mid reset PredTargetF", PredTargetF, 32'h0);
      checkOutput("mid reset RedirectE", RedirectE, 1'b1);
      checkOutput("mid reset BranchCount", BranchCount, 32'h0);
      applyStimulus(idle);
      #1;
      rst_n = 1'b1;
      step();
      check_fetch("after mid reset 0x100", 32'h100, 1'b0, 32'h0);

      // ---------------- counter training and saturation ----------------
      applyStimulus(bne_t);
      #1;
      check_redirect("BNE taken cold", 1'b1, 32'h240);
      step();
      applyStimulus(idle);
      check_fetch("BNE after taken", 32'h200, 1'b1, 32'h240);

      op = bne_nt; op.pred_taken = 1'b1; op.pred_target = 32'h240;
      applyStimulus(op);
      #1;
      check_redirect("BNE not-taken predicted", 1'b1, 32'h204);
      step();
      applyStimulus(idle);
      check_fetch("BNE cnt1", 32'h200, 1'b0, 32'h240);

      applyStimulus(bne_nt);
      #1;
      check_redirect("BNE not-taken 2", 1'b0, 32'h0);
      step();
      applyStimulus(bne_nt);
      #1;
      check_redirect("BNE saturate", 1'b0, 32'h0);
      step();
      applyStimulus(idle);
      check_fetch("BNE cnt0 saturated", 32'h200, 1'b0, 32'h240);
      applyStimulus(bne_t);
      #1;
      step();
      applyStimulus(idle);
      check_fetch("BNE cnt back to 1", 32'h200, 1'b0, 32'h240);

      // ---------------- JALR never trains ----------------
      applyStimulus(jalr_op);
      check_fetch("JALR before", 32'h300, 1'b0, 32'h0);
      check_redirect("JALR", 1'b1, 32'h1234);
      step();
      applyStimulus(idle);
      check_fetch("JALR after 0x300", 32'h300, 1'b0, 32'h0);
      check_fetch("JALR after 0x200", 32'h200, 1'b0, 32'h240);

      // ---------------- stall hold ----------------
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      model_clear();
      step();
      op = beq_cold; op.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(op);
         #1;
         checkOutput($sformatf("stall %0d RedirectE", k), RedirectE, 1'b1);
         step();
      end
      applyStimulus(beq_cold);
      step();
      applyStimulus(idle);
      check_fetch("stall release trained", 32'h100, 1'b1, 32'h140);
`ifdef BRANCH_STATS_EN
      checkOutput("stall BranchCount", BranchCount, 32'd1);
      checkOutput("stall MispredictCount", MispredictCount, 32'd1);
`else
      checkOutput("stall BranchCount", BranchCount, 32'd0);
      checkOutput("stall MispredictCount", MispredictCount, 32'd0);
`endif
      // A single decrement must drop the prediction: counter was 2, not 3.
      op = make_op(1,0,1,0,0,3'd0,32'd5,32'd6,32'h100,32'h140,0,1,32'h140);
      applyStimulus(op);
      #1;
      check_redirect("stall follow-up not-taken", 1'b1, 32'h104);
      step();
      applyStimulus(idle);
      check_fetch("single update only", 32'h100, 1'b0, 32'h140);

      // ---------------- resolution table (stalled: no training) ----------------
      vecs[0]  = make_vec(1,1,0,0,3'd0,32'd5,32'd5,32'h100,32'h140,0,0,32'h0,1,32'h140);
      vecs[1]  = make_vec(1,1,0,0,3'd0,32'd5,32'd6,32'h100,32'h140,0,0,32'h0,0,32'h0);
      vecs[2]  = make_vec(1,1,0,0,3'd1,32'd5,32'd6,32'h100,32'h140,0,1,32'h140,0,32'h0);
      vecs[3]  = make_vec(1,1,0,0,3'd1,32'd5,32'd6,32'h100,32'h140,0,1,32'h180,1,32'h140);
      vecs[4]  = make_vec(1,1,0,0,3'd4,32'hFFFFFFFF,32'd1,32'h100,32'h140,0,0,32'h0,1,32'h140);
      vecs[5]  = make_vec(1,1,0,0,3'd6,32'hFFFFFFFF,32'd1,32'h100,32'h140,0,1,32'h140,1,32'h104);
      vecs[6]  = make_vec(1,1,0,0,3'd5,32'd1,32'hFFFFFFFF,32'h100,32'h140,0,0,32'h0,1,32'h140);
      vecs[7]  = make_vec(1,1,0,0,3'd7,32'd1,32'hFFFFFFFF,32'h100,32'h140,0,0,32'h0,0,32'h0);
      vecs[8]  = make_vec(1,1,0,0,3'd2,32'd3,32'd3,32'h100,32'h140,0,1,32'h140,1,32'h104);
      vecs[9]  = make_vec(1,1,0,0,3'd3,32'd3,32'd4,32'h100,32'h140,0,0,32'h0,0,32'h0);
      vecs[10] = make_vec(1,0,1,0,3'd0,32'd0,32'd0,32'h100,32'h140,0,0,32'h0,1,32'h140);
      vecs[11] = make_vec(1,0,1,1,3'd0,32'd0,32'd0,32'h300,32'h340,32'h1235,0,32'h0,1,32'h1234);
      vecs[12] = make_vec(1,0,1,1,3'd0,32'd0,32'd0,32'h300,32'h340,32'h1235,1,32'h1234,0,32'h0);
      vecs[13] = make_vec(0,1,0,0,3'd0,32'd5,32'd5,32'h100,32'h140,0,0,32'h0,0,32'h0);
      vecs[14] = make_vec(1,1,0,0,3'd0,32'd5,32'd5,32'h100,32'h140,0,1,32'h140,0,32'h0);
      vecs[15] = make_vec(1,1,0,0,3'd5,32'd7,32'd7,32'h100,32'h140,0,0,32'h0,1,32'h140);
      vecs[16] = make_vec(1,1,0,0,3'd6,32'd1,32'hFFFFFFFF,32'h100,32'h140,0,0,32'h0,1,32'h140);
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].op);
         #1;
         check_redirect($sformatf("vec%0d", i), vecs[i].exp_redirect, vecs[i].exp_pc);
         step();
      end

      // ---------------- randomized against the model ----------------
      for (int n = 0; n < 400; n++) begin
         int kind;
         op = idle;
         kind          = int'($urandom_range(0, 9));
         op.valid      = ($urandom_range(0, 9) != 0);
         op.stall      = ($urandom_range(0, 4) == 0);
         op.branch     = (kind <= 4);
         op.jump       = (kind >= 5 && kind <= 8);
         op.jalr       = (kind >= 7 && kind <= 8);
         op.f3         = 3'($urandom_range(0, 7));
         op.a          = 32'($urandom_range(0, 3)) - 32'd2;
         op.b          = 32'($urandom_range(0, 3)) - 32'd2;
         op.pce        = rand_pc();
         op.pc_target  = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
         op.alu        = 32'h2000 + 32'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            op.pred_taken  = model_pred_taken(op.pce);
            op.pred_target = model_pred_target(op.pce);
         end else begin
            op.pred_taken  = 1'($urandom_range(0, 1));
            op.pred_target = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
         end
         applyStimulus(op);
         PCF = rand_pc();
         #1;
         nm      = $sformatf("rand%0d", n);
         exp_red = model_redirect(op);
         exp_nx  = exp_red ? model_next_pc(op) : 32'h0;
         checkOutput({nm, " PredTakenF"}, PredTakenF, model_pred_taken(PCF));
         checkOutput({nm, " PredTargetF"}, PredTargetF, model_pred_target(PCF));
         check_redirect(nm, exp_red, exp_nx);
         checkOutput({nm, " BranchCount"}, BranchCount, exp_branch_count());
         checkOutput({nm, " MispredictCount"}, MispredictCount, exp_mis_count());
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
